// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader driving the CPU programming port
//
// Receives a framed image over a valid/ready byte interface:
//   4-byte length header (MSB first), len data words (MSB byte first), 4-byte XOR checksum.
// Each data word is written to instruction memory at BASE_ADDR + 4*index through the
// CPU programming port. prog_en stays high for the whole session so the CPU PC stays parked.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   rx_data[7:0]      incoming byte
//   rx_valid          rx_data valid
//   rx_ready          loader accepts a byte (low only in DONE/ERR)
//   restart           one-cycle pulse; DONE/ERR -> IDLE
//   prog_en           programming session active (HDR/LOAD/CHK)
//   inst_addr[31:0]   programming write address
//   prog_instruction  programming write data
//   busy              session in progress
//   done              image loaded and checksum matched (held until restart/reset)
//   error             bad length or checksum mismatch (held until restart/reset)
//   words_loaded      data words written this session

module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic        prog_en,
    output logic [31:0] inst_addr,
    output logic [31:0] prog_instruction,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    // Only the three most recent bytes need storing; the fourth is taken
    // straight from rx_data on the cycle the word completes.
    logic [23:0] asm_q, asm_d;
    logic [15:0] len_q, len_d;
    logic [31:0] chk_q, chk_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] wl_q, wl_d;

    logic        accept;
    logic        word_done;
    logic [31:0] word;

    assign accept    = rx_valid && rx_ready;
    assign word_done = accept && (cnt_q == 2'd3);
    assign word      = {asm_q, rx_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        len_d   = len_q;
        chk_d   = chk_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wl_d    = wl_q;

        if (accept) begin
            asm_d = {asm_q[15:0], rx_data};
            cnt_d = cnt_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (word_done) begin
                    if ((word == 32'd0) || (word > MAX_LEN)) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = word[15:0];
                        wl_d    = 16'd0;
                        chk_d   = 32'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (word_done) begin
                    data_d = word;
                    addr_d = BASE_ADDR + {14'd0, wl_q, 2'b00};
                    chk_d  = chk_q ^ word;
                    wl_d   = wl_q + 16'd1;
                    if ((wl_q + 16'd1) == len_q) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (word_done) begin
                    state_d = (word == chk_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                    asm_d   = 24'd0;
                    chk_d   = 32'd0;
                    wl_d    = 16'd0;
                    addr_d  = BASE_ADDR;
                    data_d  = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            asm_q   <= 24'd0;
            len_q   <= 16'd0;
            chk_q   <= 32'd0;
            addr_q  <= BASE_ADDR;
            data_q  <= 32'd0;
            wl_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wl_q    <= wl_d;
        end
    end

    assign rx_ready         = (state_q != S_DONE) && (state_q != S_ERR);
    assign busy             = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
    assign prog_en          = busy;
    assign done             = (state_q == S_DONE);
    assign error            = (state_q == S_ERR);
    assign inst_addr        = addr_q;
    assign prog_instruction = data_q;
    assign words_loaded     = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a frame-parsing reference model

module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAXW = 8;

    localparam int P_IDLE = 0;
    localparam int P_HDR  = 1;
    localparam int P_LOAD = 2;
    localparam int P_CHK  = 3;
    localparam int P_DONE = 4;
    localparam int P_ERR  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        prog_en;
    logic [31:0] inst_addr;
    logic [31:0] prog_instruction;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .restart          (restart),
        .prog_en          (prog_en),
        .inst_addr        (inst_addr),
        .prog_instruction (prog_instruction),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .words_loaded     (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [7:0]  rxq[$];                  // bytes accepted this session
    logic [31:0] mem[logic [31:0]];       // emulated instruction memory
    logic [31:0] fw[$];                   // frame words for send_frame

    typedef struct {
        int          ph;
        int          wl;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    function automatic logic [31:0] wd(int k);
        return {rxq[k], rxq[k+1], rxq[k+2], rxq[k+3]};
    endfunction

    // Parse the accepted bytes as a frame and derive what the loader must show.
    function automatic exp_t model();
        exp_t        e;
        int          n;
        int          len;
        int          nw;
        logic [31:0] hdr;
        logic [31:0] acc;
        e.ph = P_IDLE; e.wl = 0; e.addr = BASE; e.data = 32'd0;
        n = rxq.size();
        if (n == 0) return e;
        if (n < 4) begin
            e.ph = P_HDR;
            return e;
        end
        hdr = wd(0);
        if (hdr == 32'd0 || hdr > 32'(MAXW)) begin
            e.ph = P_ERR;
            return e;
        end
        len = int'(hdr);
        nw  = (n - 4) / 4;
        if (nw > len) nw = len;
        acc = 32'd0;
        for (int i = 0; i < nw; i++) begin
            acc    = acc ^ wd(4 + 4 * i);
            e.data = wd(4 + 4 * i);
            e.addr = BASE + 32'(4 * i);
        end
        e.wl = nw;
        if (nw < len) begin
            e.ph = P_LOAD;
        end else if (n - 4 - 4 * len < 4) begin
            e.ph = P_CHK;
        end else begin
            e.ph = (wd(4 + 4 * len) == acc) ? P_DONE : P_ERR;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte acceptance tracking and memory emulation, on the active edge.
    always @(posedge clk) begin
        exp_t e;
        bit   fin;
        e   = model();
        fin = (e.ph == P_DONE) || (e.ph == P_ERR);
        if (reset) rxq.delete();
        else if (restart && fin) rxq.delete();
        else if (rx_valid && !fin) rxq.push_back(rx_data);
        if (prog_en === 1'b1) mem[inst_addr] = prog_instruction;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        bit   act;
        if (chk_en) begin
            e   = model();
            act = (e.ph == P_HDR) || (e.ph == P_LOAD) || (e.ph == P_CHK);
            chk("cyc_prog_en", {31'd0, prog_en}, {31'd0, act});
            chk("cyc_busy", {31'd0, busy}, {31'd0, act});
            chk("cyc_done", {31'd0, done}, {31'd0, e.ph == P_DONE});
            chk("cyc_error", {31'd0, error}, {31'd0, e.ph == P_ERR});
            chk("cyc_rx_ready", {31'd0, rx_ready}, {31'd0, !(e.ph == P_DONE || e.ph == P_ERR)});
            chk("cyc_inst_addr", inst_addr, e.addr);
            chk("cyc_prog_instruction", prog_instruction, e.data);
            chk("cyc_words_loaded", {16'd0, words_loaded}, 32'(e.wl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 3; i >= 0; i--)
            send_byte(w[8*i +: 8], stall ? 2 + int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic send_frame(input logic [31:0] cs, input bit stall);
        send_word(32'(fw.size()), stall);
        foreach (fw[i]) send_word(fw[i], stall);
        send_word(cs, stall);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        reset    = 1'b1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        chk("rst_prog_en", {31'd0, prog_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk("rst_prog_instruction", prog_instruction, 32'h0);
        chk("rst_words_loaded", {16'd0, words_loaded}, 32'd0);

        // 1: two-word image, good checksum
        mem.delete();
        fw = {32'h20080005, 32'h2009000A};
        send_frame(32'h0001000F, 1'b0);
        repeat (2) tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_words_loaded", {16'd0, words_loaded}, 32'd2);
        chk("t1_prog_en", {31'd0, prog_en}, 32'd0);
        chk("t1_mem0", mem[32'h0], 32'h20080005);
        chk("t1_mem4", mem[32'h4], 32'h2009000A);

        // 2: same image, bad checksum
        pulse_restart();
        chk("t2_idle_done", {31'd0, done}, 32'd0);
        chk("t2_idle_wl", {16'd0, words_loaded}, 32'd0);
        send_frame(32'h00000000, 1'b0);
        repeat (2) tick();
        chk("t2_error", {31'd0, error}, 32'd1);
        chk("t2_done", {31'd0, done}, 32'd0);
        chk("t2_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("t2_prog_en", {31'd0, prog_en}, 32'd0);

        // 3: bad length headers
        pulse_restart();
        mem.delete();
        send_word(32'd0, 1'b0);
        chk("t3_len0_error", {31'd0, error}, 32'd1);
        pulse_restart();
        send_word(32'(MAXW + 1), 1'b0);
        chk("t3_lenmax_error", {31'd0, error}, 32'd1);
        tick();
        chk("t3_mem_entries", 32'(mem.size()), 32'd1);
        chk("t3_mem0", mem[32'h0], 32'h0);

        // 4: test 1 with sparse rx_valid and random stalls
        pulse_restart();
        mem.delete();
        fw = {32'h20080005, 32'h2009000A};
        send_frame(32'h0001000F, 1'b1);
        repeat (2) tick();
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_words_loaded", {16'd0, words_loaded}, 32'd2);
        chk("t4_mem0", mem[32'h0], 32'h20080005);
        chk("t4_mem4", mem[32'h4], 32'h2009000A);

        // 5: reset mid-LOAD (restart ignored there), then a fresh one-word frame
        pulse_restart();
        mem.delete();
        send_word(32'd3, 1'b0);
        send_word(32'h11223344, 1'b0);
        pulse_restart();
        chk("t5_restart_ignored_busy", {31'd0, busy}, 32'd1);
        chk("t5_restart_ignored_wl", {16'd0, words_loaded}, 32'd1);
        pulse_reset();
        chk("t5_reset_busy", {31'd0, busy}, 32'd0);
        chk("t5_reset_wl", {16'd0, words_loaded}, 32'd0);
        chk("t5_reset_rx_ready", {31'd0, rx_ready}, 32'd1);
        fw = {32'hDEADBEEF};
        send_frame(32'hDEADBEEF, 1'b0);
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_words_loaded", {16'd0, words_loaded}, 32'd1);
        chk("t5_mem0", mem[32'h0], 32'hDEADBEEF);

        // 6: restart after DONE, load a zero word
        pulse_restart();
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        chk("t6_idle_done", {31'd0, done}, 32'd0);
        chk("t6_idle_addr", inst_addr, 32'h0);
        fw = {32'h00000000};
        send_frame(32'h00000000, 1'b0);
        tick();
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_mem0", mem[32'h0], 32'h0);

        // 7: largest legal length
        pulse_restart();
        mem.delete();
        fw.delete();
        x = 32'd0;
        for (int i = 0; i < MAXW; i++) begin
            fw.push_back(32'h11111111 * 32'(i));
            x = x ^ (32'h11111111 * 32'(i));
        end
        send_frame(x, 1'b0);
        tick();
        chk("t7_done", {31'd0, done}, 32'd1);
        chk("t7_words_loaded", {16'd0, words_loaded}, 32'd8);
        chk("t7_mem28", mem[32'd28], 32'h77777777);
        chk("t7_last_addr", inst_addr, 32'd28);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
